// File: rtl/pmt_fir_pkg.sv
// Shared definitions for the PMT laser FIR low-pass path: state encoding,
// depth limits and the down-sample clamp helper.
package pmt_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } fir_state_e;

  localparam int FIR_MAX_NUM      = 19;
  localparam int FIR_FLUSH_CYCLES = 40;

  function automatic logic [7:0] clamp_num(input logic [7:0] num, input logic [7:0] max_num);
    return (num > max_num) ? max_num : num;
  endfunction

endpackage

// File: rtl/fir_lp_ctrl.sv
// Sequencer around the FIR low-pass filter: drains the pipeline on every start
// or tap-count change and only releases outputs computed over a full window.
module fir_lp_ctrl
  import pmt_fir_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_NUM      = FIR_MAX_NUM,
  parameter int FLUSH_CYCLES = FIR_FLUSH_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  laser_start_i,
  input  logic [7:0]            fir_down_sample_num_i,
  input  logic                  laser_vld_i,
  input  logic [DATA_WIDTH-1:0] laser_data_i,
  output logic                  fir_start_o,
  output logic [7:0]            fir_num_o,
  output logic                  fir_laser_vld_o,
  output logic [DATA_WIDTH-1:0] fir_laser_data_o,
  input  logic                  lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0] lp_laser_data_i,
  output logic                  lp_vld_o,
  output logic [DATA_WIDTH-1:0] lp_data_o,
  output logic                  settled_o,
  output logic [1:0]            state_o
);

  localparam int               CNT_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]       MAX_NUM_L  = 8'(MAX_NUM);

  fir_state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]      flush_cnt_r, flush_cnt_nxt_s;
  logic [4:0]            drop_cnt_r, drop_cnt_nxt_s;
  logic [7:0]            fir_num_r, fir_num_nxt_s, req_num_s;
  logic                  change_s, active_s, run_s;
  logic                  fir_start_r, fir_vld_r, lp_vld_r;
  logic [DATA_WIDTH-1:0] fir_data_r, lp_data_r;

  assign req_num_s = clamp_num(fir_down_sample_num_i, MAX_NUM_L);
  assign change_s  = (req_num_s != fir_num_r);
  assign run_s     = (state_r == ST_RUN);
  assign active_s  = (state_r == ST_SETTLE) || run_s;

  // Next-state, flush/drop counters and tap-count latch
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    drop_cnt_nxt_s  = drop_cnt_r;
    fir_num_nxt_s   = fir_num_r;
    case (state_r)
      ST_IDLE: begin
        if (laser_start_i) begin
          fir_num_nxt_s   = req_num_s;
          flush_cnt_nxt_s = {CNT_W{1'b0}};
          state_nxt_s     = ST_FLUSH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (!laser_start_i) begin
          state_nxt_s = ST_IDLE;
        end else if (change_s) begin
          // A new request restarts the drain; the latest value wins
          fir_num_nxt_s   = req_num_s;
          flush_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (flush_cnt_r == FLUSH_LAST) begin
          if (fir_num_r == 8'd0) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s    = ST_SETTLE;
            drop_cnt_nxt_s = 5'd0;
          end
        end else begin
          flush_cnt_nxt_s = flush_cnt_r + CNT_ONE;
        end
      end
      ST_SETTLE, ST_RUN: begin
        if (!laser_start_i) begin
          state_nxt_s = ST_IDLE;
        end else if (change_s) begin
          fir_num_nxt_s   = req_num_s;
          flush_cnt_nxt_s = {CNT_W{1'b0}};
          state_nxt_s     = ST_FLUSH;
        end else if ((state_r == ST_SETTLE) && lp_laser_vld_i) begin
          // The fir_num-th partial output is the last one dropped
          if (drop_cnt_r == (fir_num_r[4:0] - 5'd1)) begin
            state_nxt_s = ST_RUN;
          end else begin
            drop_cnt_nxt_s = drop_cnt_r + 5'd1;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; gating uses the pre-transition state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r  <= 5'd0;
      fir_num_r   <= 8'd0;
      fir_start_r <= 1'b0;
      fir_vld_r   <= 1'b0;
      fir_data_r  <= {DATA_WIDTH{1'b0}};
      lp_vld_r    <= 1'b0;
      lp_data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      drop_cnt_r  <= drop_cnt_nxt_s;
      fir_num_r   <= fir_num_nxt_s;
      fir_start_r <= active_s;
      fir_vld_r   <= laser_vld_i & active_s;
      fir_data_r  <= laser_data_i;
      lp_vld_r    <= lp_laser_vld_i & run_s;
      if (lp_laser_vld_i && run_s) begin
        lp_data_r <= lp_laser_data_i;
      end else begin
        lp_data_r <= lp_data_r;
      end
    end
  end

  assign fir_start_o      = fir_start_r;
  assign fir_num_o        = fir_num_r;
  assign fir_laser_vld_o  = fir_vld_r;
  assign fir_laser_data_o = fir_data_r;
  assign lp_vld_o         = lp_vld_r;
  assign lp_data_o        = lp_data_r;
  assign settled_o        = run_s;
  assign state_o          = state_r;

endmodule

// File: tb/tb_fir_lp_ctrl.sv
// Bench for fir_lp_ctrl: a behavioural moving-average filter sits beside the DUT
// and tags every output with its index and whether its window was full.
module tb_fir_lp_ctrl;

  localparam int DW   = 16;
  localparam int LAT  = 3;
  localparam int MAXN = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    num = 8'd0;
  logic          laser_vld = 1'b0;
  logic [DW-1:0] laser_data = '0;
  logic          fir_start_o, fir_laser_vld_o, lp_vld_o, settled_o;
  logic [7:0]    fir_num_o;
  logic [DW-1:0] fir_laser_data_o, lp_data_o;
  logic [1:0]    state_o;
  logic          lp_laser_vld_i = 1'b0;
  logic [DW-1:0] lp_laser_data_i = '0;

  int errors = 0;
  int checks = 0;
  bit rand_vld = 1'b0;

  always #5 clk = ~clk;

  fir_lp_ctrl #(.DATA_WIDTH(DW), .MAX_NUM(MAXN), .FLUSH_CYCLES(40)) dut (
    .clk_i(clk), .rst_i(rst), .laser_start_i(start), .fir_down_sample_num_i(num),
    .laser_vld_i(laser_vld), .laser_data_i(laser_data),
    .fir_start_o(fir_start_o), .fir_num_o(fir_num_o),
    .fir_laser_vld_o(fir_laser_vld_o), .fir_laser_data_o(fir_laser_data_o),
    .lp_laser_vld_i(lp_laser_vld_i), .lp_laser_data_i(lp_laser_data_i),
    .lp_vld_o(lp_vld_o), .lp_data_o(lp_data_o), .settled_o(settled_o), .state_o(state_o)
  );

  // Filter model and forwarded-output log, evaluated away from the active edge
  int p_vld[LAT] = '{default: 0};
  int p_data[LAT], p_k[LAT], p_full[LAT];
  int o_k = 0, o_full = 0, o_data = 0, fk = 0, last_exp = 0;
  int win[$];
  int log_k[$], log_full[$], log_got[$], log_exp[$];

  always @(negedge clk) begin
    int sum;
    if (lp_vld_o === 1'b1) begin
      log_k.push_back(o_k); log_full.push_back(o_full);
      log_got.push_back(int'(lp_data_o)); log_exp.push_back(o_data);
      last_exp = o_data;
    end
    lp_laser_vld_i  = (p_vld[LAT-1] != 0);
    lp_laser_data_i = DW'(p_data[LAT-1]);
    o_k = p_k[LAT-1]; o_full = p_full[LAT-1]; o_data = p_data[LAT-1];
    for (int i = LAT - 1; i > 0; i--) begin
      p_vld[i] = p_vld[i-1]; p_data[i] = p_data[i-1]; p_k[i] = p_k[i-1]; p_full[i] = p_full[i-1];
    end
    p_vld[0] = 0;
    if (fir_start_o !== 1'b1) begin
      win.delete();
      fk = 0;
    end else if (fir_laser_vld_o === 1'b1) begin
      win.push_back(int'(fir_laser_data_o));
      if (win.size() > int'(fir_num_o) + 1) void'(win.pop_front());
      fk++;
      sum = 0;
      foreach (win[i]) sum += win[i];
      p_vld[0] = 1; p_k[0] = fk;
      p_data[0] = sum / (int'(fir_num_o) + 1);
      p_full[0] = (win.size() == int'(fir_num_o) + 1) ? 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    laser_vld  = rand_vld ? 1'($urandom_range(0, 1)) : 1'b1;
    laser_data = DW'($urandom);
  endtask

  function automatic void clear_log();
    log_k.delete(); log_full.delete(); log_got.delete(); log_exp.delete();
  endfunction

  // first_k: index of first forwarded output; bad: forwarded outputs that were partial or corrupted
  function automatic void scan_log(output int first_k, output int bad, output int cnt);
    first_k = (log_k.size() > 0) ? log_k[0] : -1;
    cnt = log_k.size();
    bad = 0;
    foreach (log_k[i]) if (log_full[i] == 0 || log_got[i] != log_exp[i]) bad++;
  endfunction

  function automatic int clamp(int n);
    return (n > MAXN) ? MAXN : n;
  endfunction

  task automatic measure_flush(input int change_at, input logic [7:0] new_num,
                               output int len, output bit gate_bad);
    int w = 0;
    len = 0; gate_bad = 1'b0;
    while (state_o != 2'd1 && w < 200) begin tick(); w++; end
    while (state_o == 2'd1 && len < 500) begin
      len++;
      if (len >= 2 && (fir_start_o || fir_laser_vld_o)) gate_bad = 1'b1;
      if (len == 2) clear_log();
      if (len == change_at) num = new_num;
      tick();
    end
  endtask

  task automatic wait_settled(output bit to);
    int w = 0;
    while (!settled_o && w < 400) begin tick(); w++; end
    to = !settled_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num = 8'd0;
    tick(); tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (fir_start_o !== 1'b0) begin errors++; $display("FAIL reset_fir_start: got %0b expected 0", fir_start_o); end
    checks++; if (fir_num_o !== 8'd0) begin errors++; $display("FAIL reset_fir_num: got %0d expected 0", fir_num_o); end
    checks++; if (fir_laser_vld_o !== 1'b0) begin errors++; $display("FAIL reset_fir_vld: got %0b expected 0", fir_laser_vld_o); end
    checks++; if (fir_laser_data_o !== '0) begin errors++; $display("FAIL reset_fir_data: got %0d expected 0", fir_laser_data_o); end
    checks++; if (lp_vld_o !== 1'b0 || lp_data_o !== '0) begin errors++; $display("FAIL reset_lp: got vld=%0b data=%0d expected 0/0", lp_vld_o, lp_data_o); end
    checks++; if (settled_o !== 1'b0) begin errors++; $display("FAIL reset_settled: got %0b expected 0", settled_o); end
    rst = 1'b0;
  endtask

  task automatic run_and_check(input string name, input int req, input int change_at, input int new_req);
    int len, fkk, bad, cnt, n_eff;
    bit gb, to;
    num = 8'(req);
    measure_flush(change_at, 8'(new_req), len, gb);
    n_eff = clamp((change_at > 0) ? new_req : req);
    checks++; if (len != ((change_at > 0) ? change_at + 40 : 40)) begin errors++; $display("FAIL %s_flush_len: got %0d expected %0d", name, len, (change_at > 0) ? change_at + 40 : 40); end
    checks++; if (gb) begin errors++; $display("FAIL %s_flush_gating: got start/vld high during flush expected low", name); end
    checks++; if (state_o !== ((n_eff == 0) ? 2'd3 : 2'd2)) begin errors++; $display("FAIL %s_post_flush_state: got %0d expected %0d", name, state_o, (n_eff == 0) ? 3 : 2); end
    checks++; if (fir_num_o !== 8'(n_eff)) begin errors++; $display("FAIL %s_fir_num: got %0d expected %0d", name, fir_num_o, n_eff); end
    wait_settled(to);
    checks++; if (to) begin errors++; $display("FAIL %s_settle_timeout: got settled=0 expected 1", name); end
    repeat (30) tick();
    scan_log(fkk, bad, cnt);
    checks++; if (fkk != n_eff + 1) begin errors++; $display("FAIL %s_first_fwd: got output #%0d expected #%0d", name, fkk, n_eff + 1); end
    checks++; if (bad != 0 || cnt == 0) begin errors++; $display("FAIL %s_fwd_data: got %0d bad of %0d expected 0 bad of >0", name, bad, cnt); end
  endtask

  task automatic test_basic();
    start = 1'b1;
    run_and_check("basic", 3, 0, 0);
    checks++; if (settled_o !== 1'b1 || fir_start_o !== 1'b1) begin errors++; $display("FAIL basic_run: got settled=%0b start=%0b expected 1/1", settled_o, fir_start_o); end
  endtask

  task automatic test_zero();  run_and_check("zero", 0, 0, 0);   endtask
  task automatic test_clamp(); run_and_check("clamp", 25, 0, 0); endtask

  task automatic test_live_change();
    run_and_check("live_a", 3, 0, 0);
    rand_vld = 1'b1;
    run_and_check("live_b", 7, 0, 0);
    rand_vld = 1'b0;
  endtask

  task automatic test_mid_flush(); run_and_check("midflush", 5, 20, 9); endtask

  task automatic test_start_fall_reset();
    bit to;
    int len;
    bit gb;
    num = 8'd3;
    measure_flush(0, 8'd0, len, gb);
    tick();
    checks++; if (state_o !== 2'd2 || fir_start_o !== 1'b1) begin errors++; $display("FAIL fall_in_settle: got state=%0d start=%0b expected 2/1", state_o, fir_start_o); end
    start = 1'b0;
    tick();
    checks++; if (state_o !== 2'd0 || fir_start_o !== 1'b1) begin errors++; $display("FAIL fall_idle: got state=%0d start=%0b expected 0/1", state_o, fir_start_o); end
    tick();
    checks++; if (fir_start_o !== 1'b0) begin errors++; $display("FAIL fall_start_low: got %0b expected 0", fir_start_o); end
    checks++; if (lp_data_o !== DW'(last_exp)) begin errors++; $display("FAIL fall_lp_hold: got %0d expected %0d", lp_data_o, last_exp); end
    start = 1'b1;
    wait_settled(to);
    checks++; if (to) begin errors++; $display("FAIL rst_run_timeout: got settled=0 expected 1"); end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++; if ({fir_start_o, fir_laser_vld_o, lp_vld_o, settled_o, state_o, fir_num_o} !== 14'd0 ||
                  fir_laser_data_o !== '0 || lp_data_o !== '0) begin
      errors++; $display("FAIL midrun_reset: got start=%0b vld=%0b lpv=%0b set=%0b st=%0d num=%0d fd=%0d lpd=%0d expected all 0",
                         fir_start_o, fir_laser_vld_o, lp_vld_o, settled_o, state_o, fir_num_o, fir_laser_data_o, lp_data_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_toggle();
    bit to;
    start = 1'b1;
    num = 8'd2;
    wait_settled(to);
    repeat (5) tick();
    start = 1'b0;
    tick();
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL toggle_idle: got %0d expected 0", state_o); end
    start = 1'b1;
    tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL toggle_flush: got %0d expected 1", state_o); end
    run_and_check("toggle", 2, 0, 0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      do n = $urandom_range(1, 30); while (clamp(n) == int'(fir_num_o));
      rand_vld = 1'($urandom_range(0, 1));
      run_and_check("random", n, 0, 0);
    end
    rand_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_live_change();
    test_mid_flush();
    test_start_fall_reset();
    test_toggle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
